// File: rtl/common_pkg.sv
// Shared machine-type definitions and raster geometry constants for the
// video timing generator and the CPU clock/contention controller.
package common;

    typedef enum logic [1:0] {
        MACHINE_S48  = 2'd0,
        MACHINE_S128 = 2'd1,
        MACHINE_S3   = 2'd2,
        MACHINE_PENT = 2'd3
    } machine_t;

    typedef struct packed {
        logic [8:0] h_total;
        logic [8:0] v_total;
    } geom_t;

    localparam logic [8:0] H_TOTAL_S48  = 9'd448;
    localparam logic [8:0] H_TOTAL_S128 = 9'd456;
    localparam logic [8:0] H_TOTAL_PENT = 9'd448;
    localparam logic [8:0] V_TOTAL_S48  = 9'd312;
    localparam logic [8:0] V_TOTAL_S128 = 9'd311;
    localparam logic [8:0] V_TOTAL_PENT = 9'd320;

    localparam logic [8:0] HBLANK_BEG = 9'd320;
    localparam logic [8:0] HBLANK_END = 9'd415;
    localparam logic [8:0] HSYNC_BEG  = 9'd328;
    localparam logic [8:0] HSYNC_END  = 9'd359;

    localparam logic [8:0] VBLANK_BEG_128  = 9'd248;
    localparam logic [8:0] VBLANK_END_128  = 9'd255;
    localparam logic [8:0] VSYNC_BEG_128   = 9'd248;
    localparam logic [8:0] VSYNC_END_128   = 9'd251;
    localparam logic [8:0] VBLANK_BEG_PENT = 9'd240;
    localparam logic [8:0] VBLANK_END_PENT = 9'd255;
    localparam logic [8:0] VSYNC_BEG_PENT  = 9'd240;
    localparam logic [8:0] VSYNC_END_PENT  = 9'd243;

    localparam logic [8:0] SCREEN_W = 9'd256;
    localparam logic [8:0] SCREEN_H = 9'd192;

    // S3 shares the 128K frame geometry.
    function automatic geom_t geom(input machine_t m);
        geom_t g;
        case (m)
            MACHINE_S48:  g = '{h_total: H_TOTAL_S48,  v_total: V_TOTAL_S48};
            MACHINE_PENT: g = '{h_total: H_TOTAL_PENT, v_total: V_TOTAL_PENT};
            default:      g = '{h_total: H_TOTAL_S128, v_total: V_TOTAL_S128};
        endcase
        return g;
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster counter and decoder: hc/vc at the 7 MHz pixel rate plus contention,
// paper, blanking and sync flags aligned with the counter values they describe.
module video_timing
    import common::*;
#(
    parameter int CONT_ADV = 2
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ck7,
    input  machine_t   machine,
    output logic [8:0] hc,
    output logic [8:0] vc,
    output logic       screen_contention,
    output logic       screen,
    output logic       blank,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    geom_t      g;
    logic       h_wrap, v_wrap, frame_wrap;
    logic [8:0] hc_d, hc_q, vc_d, vc_q, hcc;
    logic [8:0] vblank_beg, vblank_end, vsync_beg, vsync_end;
    machine_t   machine_d, machine_q;
    logic       cont_d, cont_q, screen_d, screen_q, blank_d, blank_q;
    logic       hsync_d, hsync_q, vsync_d, vsync_q, frame_start_d, frame_start_q;

    always_comb begin
        g          = geom(machine_q);
        h_wrap     = (hc_q == g.h_total - 9'd1);
        v_wrap     = (vc_q == g.v_total - 9'd1);
        frame_wrap = ck7 && h_wrap && v_wrap;

        hc_d      = hc_q;
        vc_d      = vc_q;
        machine_d = machine_q;
        if (ck7) begin
            hc_d = h_wrap ? 9'd0 : hc_q + 9'd1;
            if (h_wrap) begin
                vc_d = v_wrap ? 9'd0 : vc_q + 9'd1;
            end
        end
        // Geometry only changes at 0/0, so a shorter new frame never cuts a line short.
        if (frame_wrap) begin
            machine_d = machine;
        end

        if (machine_d == MACHINE_PENT) begin
            vblank_beg = VBLANK_BEG_PENT;
            vblank_end = VBLANK_END_PENT;
            vsync_beg  = VSYNC_BEG_PENT;
            vsync_end  = VSYNC_END_PENT;
        end else begin
            vblank_beg = VBLANK_BEG_128;
            vblank_end = VBLANK_END_128;
            vsync_beg  = VSYNC_BEG_128;
            vsync_end  = VSYNC_END_128;
        end

        // The advance wraps modulo 512, so the line tail always reads as free.
        hcc = hc_d + 9'(CONT_ADV);

        cont_d        = cont_q;
        screen_d      = screen_q;
        blank_d       = blank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_wrap;
        if (ck7) begin
            cont_d   = (vc_d < SCREEN_H) && (hcc < SCREEN_W) && (hcc[3:1] < 3'd6);
            screen_d = (hc_d < SCREEN_W) && (vc_d < SCREEN_H);
            blank_d  = ((hc_d >= HBLANK_BEG) && (hc_d <= HBLANK_END)) ||
                       ((vc_d >= vblank_beg) && (vc_d <= vblank_end));
            hsync_d  = (hc_d >= HSYNC_BEG) && (hc_d <= HSYNC_END);
            vsync_d  = (vc_d >= vsync_beg) && (vc_d <= vsync_end);
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            hc_q          <= 9'd0;
            vc_q          <= 9'd0;
            machine_q     <= machine;
            cont_q        <= 1'b0;
            screen_q      <= 1'b1;
            blank_q       <= 1'b0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            machine_q     <= machine_d;
            cont_q        <= cont_d;
            screen_q      <= screen_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hc                = hc_q;
    assign vc                = vc_q;
    assign screen_contention = cont_q;
    assign screen            = screen_q;
    assign blank             = blank_q;
    assign hsync             = hsync_q;
    assign vsync             = vsync_q;
    assign frame_start       = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: table of first-line pixel checks, whole-frame runs
// per machine against a position-based reference model, and a mid-frame reset.
`timescale 1ns/1ps
module tb_video_timing;
    import common::*;

    localparam int CONT_ADV = 2;

    logic       clk28 = 1'b0;
    logic       rst, ck7;
    machine_t   machine;
    logic [8:0] hc, vc;
    logic       screen_contention, screen, blank, hsync, vsync, frame_start;

    video_timing #(.CONT_ADV(CONT_ADV)) dut (
        .clk28(clk28), .rst(rst), .ck7(ck7), .machine(machine),
        .hc(hc), .vc(vc), .screen_contention(screen_contention),
        .screen(screen), .blank(blank), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start)
    );

    always #5 clk28 = ~clk28;

    int total = 0;
    int bad   = 0;

    // Reference model: position within the frame as a single strobe count.
    int       m_tick = 0;
    machine_t m_mach = MACHINE_S48;
    bit       m_fs   = 1'b0;
    bit       m_hold = 1'b1;
    int       strobes_since = 0;
    bit       vs_seen = 1'b0;
    int       dut_vs_vc = -1;

    typedef struct {
        int hc;
        bit cont;
        bit scr;
        bit blk;
        bit hs;
    } vec_t;

    function automatic int h_of(input machine_t m);
        if (m == MACHINE_S48 || m == MACHINE_PENT) return 448;
        return 456;
    endfunction

    function automatic int v_of(input machine_t m);
        if (m == MACHINE_S48) return 312;
        if (m == MACHINE_PENT) return 320;
        return 311;
    endfunction

    function automatic logic [23:0] model_out();
        int h, hcm, vcm, hcc, vb;
        bit cont, scr, blk, hs, vs;
        if (m_hold) return {9'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        h    = h_of(m_mach);
        hcm  = m_tick % h;
        vcm  = m_tick / h;
        hcc  = (hcm + CONT_ADV) % 512;
        cont = (vcm < 192) && (hcc < 256) && (((hcc / 2) % 8) < 6);
        scr  = (hcm < 256) && (vcm < 192);
        vb   = (m_mach == MACHINE_PENT) ? 240 : 248;
        blk  = (hcm >= 320 && hcm <= 415) || (vcm >= vb && vcm <= 255);
        hs   = (hcm >= 328 && hcm <= 359);
        vs   = (vcm >= vb && vcm <= vb + 3);
        return {9'(hcm), 9'(vcm), cont, scr, blk, hs, vs, m_fs};
    endfunction

    task automatic finish_tb();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
            if (bad >= 50) finish_tb();
        end
    endtask

    task automatic check_model();
        logic [23:0] act, exp;
        act = {hc, vc, screen_contention, screen, blank, hsync, vsync, frame_start};
        exp = model_out();
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL model: got {hc,vc,flags}=%h expected %h (tick=%0d) at %0t",
                     act, exp, m_tick, $time);
            if (bad >= 50) finish_tb();
        end
    endtask

    task automatic cyc(input bit r, input bit s, input machine_t m);
        rst = r;
        ck7 = s;
        machine = m;
        @(posedge clk28);
        if (r) begin
            m_tick = 0;
            m_mach = m;
            m_fs   = 1'b0;
            m_hold = 1'b1;
            strobes_since = 0;
        end else if (s) begin
            m_hold = 1'b0;
            strobes_since++;
            m_tick++;
            if (m_tick == h_of(m_mach) * v_of(m_mach)) begin
                m_tick = 0;
                m_mach = m;
                m_fs   = 1'b1;
            end else begin
                m_fs = 1'b0;
            end
        end else begin
            m_fs = 1'b0;
        end
        #1;
        check_model();
        if (vsync && !vs_seen) begin
            vs_seen   = 1'b1;
            dut_vs_vc = int'(vc);
        end
    endtask

    task automatic step4(input machine_t m);
        cyc(1'b0, 1'b1, m);
        for (int j = 0; j < 3; j++) cyc(1'b0, 1'b0, m);
    endtask

    task automatic run_frame(input int exp_len, input int exp_vs, input machine_t next);
        bit done;
        machine_t m;
        done    = 1'b0;
        vs_seen = 1'b0;
        dut_vs_vc = -1;
        for (int k = 0; k < 200000 && !done; k++) begin
            if (m_tick / h_of(m_mach) < 100) m = machine_t'($urandom_range(0, 3));
            else m = next;
            cyc(1'b0, ($urandom % 16) != 0, m);
            if (!m_hold && m_mach == MACHINE_S128 && m_tick == 247 * 456)
                check("s128_vc247_blank", int'(blank), 0);
            if (!m_hold && m_mach == MACHINE_S128 && m_tick == 248 * 456)
                check("s128_vc248_blank", int'(blank), 1);
            if (frame_start) begin
                check("frame_len", strobes_since, exp_len);
                check("frame_start_hc", int'(hc), 0);
                check("frame_start_vc", int'(vc), 0);
                strobes_since = 0;
                done = 1'b1;
            end
        end
        if (!done) check("frame_timeout", 0, 1);
        check("vsync_first_vc", dut_vs_vc, exp_vs);
    endtask

    initial begin
        vec_t tbl[$];
        int   guard;

        tbl = '{
            '{1,   1, 1, 0, 0}, '{9,   1, 1, 0, 0}, '{10,  0, 1, 0, 0},
            '{13,  0, 1, 0, 0}, '{14,  1, 1, 0, 0}, '{25,  1, 1, 0, 0},
            '{26,  0, 1, 0, 0}, '{249, 1, 1, 0, 0}, '{250, 0, 1, 0, 0},
            '{253, 0, 1, 0, 0}, '{254, 0, 1, 0, 0}, '{255, 0, 1, 0, 0},
            '{256, 0, 0, 0, 0}, '{319, 0, 0, 0, 0}, '{320, 0, 0, 1, 0},
            '{327, 0, 0, 1, 0}, '{328, 0, 0, 1, 1}, '{359, 0, 0, 1, 1},
            '{360, 0, 0, 1, 0}, '{415, 0, 0, 1, 0}, '{416, 0, 0, 0, 0},
            '{447, 0, 0, 0, 0}
        };

        rst = 1'b1;
        ck7 = 1'b0;
        machine = MACHINE_S48;

        // Reset wins over ck7 on the same edge.
        cyc(1'b1, 1'b0, MACHINE_S48);
        cyc(1'b1, 1'b1, MACHINE_S48);
        cyc(1'b1, 1'b1, MACHINE_S48);
        check("rst_hc", int'(hc), 0);
        check("rst_vc", int'(vc), 0);
        check("rst_screen", int'(screen), 1);
        check("rst_cont", int'(screen_contention), 0);
        check("rst_blank", int'(blank), 0);
        check("rst_hsync", int'(hsync), 0);
        check("rst_vsync", int'(vsync), 0);
        check("rst_frame_start", int'(frame_start), 0);

        // First line with ck7 on every 4th clk28.
        foreach (tbl[i]) begin
            guard = 0;
            while (m_tick != tbl[i].hc && guard < 2000) begin
                step4(MACHINE_S48);
                guard++;
            end
            check($sformatf("line0_hc%0d_hc", tbl[i].hc), int'(hc), tbl[i].hc);
            check($sformatf("line0_hc%0d_cont", tbl[i].hc), int'(screen_contention), int'(tbl[i].cont));
            check($sformatf("line0_hc%0d_screen", tbl[i].hc), int'(screen), int'(tbl[i].scr));
            check($sformatf("line0_hc%0d_blank", tbl[i].hc), int'(blank), int'(tbl[i].blk));
            check($sformatf("line0_hc%0d_hsync", tbl[i].hc), int'(hsync), int'(tbl[i].hs));
        end
        check("line0_end_vc", int'(vc), 0);
        step4(MACHINE_S48);
        check("line1_hc", int'(hc), 0);
        check("line1_vc", int'(vc), 1);

        run_frame(448 * 312, 248, MACHINE_PENT);
        run_frame(448 * 320, 240, MACHINE_S128);
        run_frame(456 * 311, 248, MACHINE_S3);

        // Mid-line reset inside an S3 frame.
        guard = 0;
        while (m_tick != 200 * 456 + 100 && guard < 200000) begin
            cyc(1'b0, ($urandom % 16) != 0, machine_t'($urandom_range(0, 3)));
            guard++;
        end
        check("pre_rst_vc", int'(vc), 200);
        cyc(1'b1, 1'b1, MACHINE_S48);
        check("midrst_hc", int'(hc), 0);
        check("midrst_vc", int'(vc), 0);
        check("midrst_vsync", int'(vsync), 0);
        check("midrst_screen", int'(screen), 1);
        cyc(1'b0, 1'b1, MACHINE_S48);
        check("after_rst_hc", int'(hc), 1);
        for (int k = 0; k < 20; k++) cyc(1'b0, k[0], MACHINE_S48);

        finish_tb();
    end

endmodule
